// File: rtl/fsm_burst_rd_if.sv
// Command/status bundle between a burst command source and the read sequencer.
// The master side issues go/len and reflects the target's ws; the slave side is the sequencer.
interface fsm_burst_rd_if #(
    parameter int LEN_W = 4
);
    logic             go;
    logic [LEN_W-1:0] len;
    logic             ws;
    logic             rd;
    logic             ds;
    logic             err;
    logic             busy;
    logic [LEN_W-1:0] beat;

    modport master (
        output go, len, ws,
        input  rd, ds, err, busy, beat
    );

    modport slave (
        input  go, len, ws,
        output rd, ds, err, busy, beat
    );
endinterface

// File: rtl/fsm_burst_rd.sv
// One-hot read sequencer for len+1 beat bursts throttled by wait states.
// Optional retry-limit abort is compiled in with FSM_BURST_RD_TIMEOUT_EN.
module fsm_burst_rd #(
    parameter int LEN_W     = 4,
    parameter int RETRY_W   = 3,
    parameter int MAX_RETRY = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fsm_burst_rd_if.slave bus
);

    if (MAX_RETRY < 1 || MAX_RETRY >= (1 << RETRY_W)) begin : g_cfg_chk
        $error("fsm_burst_rd: MAX_RETRY must lie in 1..2**RETRY_W-1");
    end

`ifdef FSM_BURST_RD_TIMEOUT_EN
    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        READ = 5'b00010,
        DLY  = 5'b00100,
        DONE = 5'b01000,
        ERR  = 5'b10000
    } state_t;

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_n;
    logic               err_q;
`else
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        READ = 4'b0010,
        DLY  = 4'b0100,
        DONE = 4'b1000
    } state_t;
`endif

    state_t           state_q;
    state_t           state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_n;
    logic [LEN_W-1:0] beat_q;
    logic [LEN_W-1:0] beat_n;
    logic             rd_q;
    logic             ds_q;
    logic             busy_q;

    // Any encoding outside the legal one-hot set falls through to IDLE.
    always_comb begin
        state_n = IDLE;
        len_n   = len_q;
        beat_n  = beat_q;
`ifdef FSM_BURST_RD_TIMEOUT_EN
        retry_n = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_n = READ;
                    len_n   = bus.len;
                    beat_n  = '0;
`ifdef FSM_BURST_RD_TIMEOUT_EN
                    retry_n = '0;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            READ: state_n = DLY;
            DLY: begin
                if (!bus.ws) begin
                    if (beat_q == len_q) begin
                        state_n = DONE;
                    end else begin
                        state_n = READ;
                        beat_n  = beat_q + 1'b1;
`ifdef FSM_BURST_RD_TIMEOUT_EN
                        retry_n = '0;
`endif
                    end
                end else begin
`ifdef FSM_BURST_RD_TIMEOUT_EN
                    if (retry_q == RETRY_MAX) begin
                        state_n = ERR;
                    end else begin
                        state_n = READ;
                        retry_n = retry_q + 1'b1;
                    end
`else
                    state_n = READ;
`endif
                end
            end
            DONE: state_n = IDLE;
`ifdef FSM_BURST_RD_TIMEOUT_EN
            ERR:  state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            rd_q    <= 1'b0;
            ds_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FSM_BURST_RD_TIMEOUT_EN
            retry_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            len_q   <= len_n;
            beat_q  <= beat_n;
            rd_q    <= (state_n == READ) || (state_n == DLY);
            ds_q    <= (state_n == DONE);
            busy_q  <= (state_n != IDLE);
`ifdef FSM_BURST_RD_TIMEOUT_EN
            retry_q <= retry_n;
            err_q   <= (state_n == ERR);
`endif
        end
    end

    assign bus.rd   = rd_q;
    assign bus.ds   = ds_q;
    assign bus.busy = busy_q;
    assign bus.beat = beat_q;
`ifdef FSM_BURST_RD_TIMEOUT_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif

endmodule

// File: doc/fsm_burst_rd.md
# fsm_burst_rd

Parametrised one-hot read-sequencing FSM for multi-beat read bursts. It is started by `go` and throttled by the wait-state input `ws`. For each beat it asserts a registered read strobe `rd` and signals burst completion with a one-cycle `ds` pulse. An optional retry-limit timeout aborts a stalled burst with an `err` pulse. It sits between a command source and a slow read target that inserts wait states.

## Interface
- `LEN_W`, default 4: width of the `len` input. A burst is `len+1` beats, so 1..2^LEN_W.
- `RETRY_W`, default 3: width of the per-beat retry counter. Used only with the timeout feature.
- `MAX_RETRY`, default 5: retries allowed per beat before abort. Must satisfy 1 ≤ MAX_RETRY < 2^RETRY_W.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  burst request. Sampled only in IDLE.
- `len`  in  LEN_W  beat count minus one. Captured when `go` is accepted.
- `ws`  in  1  wait-state from the target. Sampled only in DLY.
- `rd`  out  1  registered read strobe.
- `ds`  out  1  registered done pulse, one cycle.
- `err`  out  1  registered abort pulse, one cycle. Constant 0 when the timeout feature is compiled out.
- `busy`  out  1  registered; high whenever the state is not IDLE.
- `beat`  out  LEN_W  registered index of the current beat, starting at 0.

## Operation
- State register is one-hot with bits IDLE, READ, DLY, DONE, ERR. The ERR bit exists only with the timeout feature.
- On reset: state = IDLE only; `rd`, `ds`, `err` and `busy` = 0; `beat` = 0; captured length = 0; retry count = 0.
- Transitions:
  - IDLE: `go`=1 goes to READ, captures `len` and clears `beat` and retry count. Otherwise stay in IDLE.
  - READ: always goes to DLY.
  - DLY with `ws`=0 (beat complete), not the last beat: go to READ, `beat` increments, retry count clears.
  - DLY with `ws`=0 on the last beat (`beat` equals captured length): go to DONE.
  - DLY with `ws`=1 (retry the same beat): go to READ and increment retry count. With the timeout feature, if retry count already equals MAX_RETRY, go to ERR instead.
  - DONE: always goes to IDLE.
  - ERR: always goes to IDLE.
- Output decode uses the next state, registered at the same edge the state updates:
  - `rd` = next state is READ or DLY.
  - `ds` = next state is DONE.
  - `err` = next state is ERR.
  - `busy` = next state is not IDLE.
- `go` is ignored in every state except IDLE. A `len` change after `go` is accepted has no effect on the current burst.
- An illegal state (not exactly one-hot) goes to IDLE on the next edge, with all pulse outputs 0.

## Timing
- Let `go` be sampled at edge k.
  - At edge k: state = READ, `rd`=1, `busy`=1.
  - At edge k+1: state = DLY, `rd`=1.
- Zero-wait burst of N beats:
  - `rd` is high for 2N consecutive cycles.
  - `ds`=1 at edge k+2N, with `rd`=0 in that cycle.
  - Edge k+2N+1 returns to IDLE with `busy`=0.
- Each `ws`=1 sample in DLY adds exactly 2 cycles (READ+DLY) to the burst. `rd` stays high throughout.
- Back-to-back bursts: there is a minimum of one IDLE cycle between `ds` and the next READ. `go` held high through DONE starts the next burst at the edge after IDLE is entered.
- `beat` updates at the same edge as the DLY→READ transition and holds through DONE/ERR. It clears only on the next accepted `go`.
- Reset asserted mid-burst clears all state and outputs immediately (asynchronously). No `ds` or `err` is produced for the aborted burst.

## Configuration
- Macro: `FSM_BURST_RD_TIMEOUT_EN`.
- Defined:
  - The ERR state and the RETRY_W-bit retry counter are present.
  - On a beat's (MAX_RETRY+1)-th `ws`=1 sample in DLY, the FSM goes to ERR. `err`=1 and `rd`=0 for one cycle, then the FSM returns to IDLE.
  - `ds` is not asserted for that burst.
- Undefined:
  - There is no ERR state and no retry counter.
  - Unlimited retries are allowed and `err` is tied to 0.
  - `RETRY_W` and `MAX_RETRY` are unused.

## Test plan
- Reset check: assert `rst_n`=0 mid-DLY of a 4-beat burst → all outputs 0 and `beat`=0 immediately. After release, idle with `busy`=0 until `go`.
- Single beat, no waits: `len`=0, `go` pulse, `ws`=0 → `rd` high 2 cycles, `ds` high 1 cycle at edge k+2, `busy` low at k+3.
- Multi-beat with waits: `len`=2, `ws`=1 on the first DLY of beat 1 only → `rd` high 8 cycles, `beat` steps 0,1,2, single `ds` at edge k+8.
- Timeout (macro on, MAX_RETRY=2): `len`=3, `ws` held 1 → READ/DLY repeats 3 times, then `err`=1 one cycle, no `ds`, `beat`=0, back to IDLE.
- Ignored `go`: `go` held high for the whole of a 2-beat burst with `len` toggling → exactly one burst of 2 beats. The next burst starts one cycle after DONE with the newly captured `len`.
- Macro off, `ws` held 1 for 20 DLY samples then 0 → no `err`, burst completes with `ds`.
